// File: rtl/minimax_mem_pkg.sv
// Shared types and helpers for the minimax memory responder.
package minimax_mem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_e;

  localparam logic [31:0] EXIT_ADDR_DEF = 32'hfffffffc;

  // Per byte lane: take new_w where mask is set, otherwise keep old_w.
  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/minimax_sram_bank_mux.sv
// Maps the responder's single SRAM port onto four 512x32 synchronous banks.
module minimax_sram_bank_mux
  import minimax_mem_pkg::*;
#(
  parameter int ADDR_BITS = 13
) (
  input  logic                 clk,
  input  logic                 sram_en,
  input  logic [ADDR_BITS-3:0] sram_addr,
  input  logic                 sram_wen,
  input  logic [31:0]          sram_wdata,
  output logic [31:0]          sram_rdata
);

  logic [1:0]  w_bank;
  logic [8:0]  w_idx;
  logic [1:0]  r_bank_sel;
  logic [31:0] r_rd  [4];
  logic [31:0] r_mem [4][512];

  assign w_bank = sram_addr[ADDR_BITS-3:ADDR_BITS-4];
  assign w_idx  = sram_addr[8:0];

  for (genvar b = 0; b < 4; b++) begin : g_bank
    // One bank: word write or registered read when selected.
    always_ff @(posedge clk) begin
      if (sram_en && (w_bank == 2'(b))) begin
        if (sram_wen) begin
          r_mem[b][w_idx] <= sram_wdata;
        end else begin
          r_rd[b] <= r_mem[b][w_idx];
        end
      end
    end
  end

  // Remember which bank answered so its data can be selected next cycle.
  always_ff @(posedge clk) begin
    if (sram_en) begin
      r_bank_sel <= w_bank;
    end
  end

  always_comb begin
    sram_rdata = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      sram_rdata = sram_rdata | (r_rd[b] & {32{r_bank_sel == 2'(b)}});
    end
  end

endmodule

// File: rtl/minimax_mem_responder.sv
// Arbitrates minimax fetch and data traffic onto one word-write SRAM port,
// with read-modify-write for partial stores and a sticky exit register.
module minimax_mem_responder
  import minimax_mem_pkg::*;
#(
  parameter int          PC_BITS   = 13,
  parameter int          ADDR_BITS = 13,
  parameter logic [31:0] EXIT_ADDR = EXIT_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [PC_BITS-1:0]   inst_addr,
  input  logic                 inst_regce,
  output logic [15:0]          inst,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wmask,
  input  logic                 rreq,
  output logic [31:0]          rdata,
  output logic                 stall,
  output logic                 sram_en,
  output logic [ADDR_BITS-3:0] sram_addr,
  output logic                 sram_wen,
  output logic [31:0]          sram_wdata,
  input  logic [31:0]          sram_rdata,
  output logic                 exit_valid,
  output logic [31:0]          exit_code
);

  state_e      r_state;
  logic        r_load_pend, r_load_exit, r_fetch_pend, r_inst_hi;
  logic [15:0] r_inst_lat, r_inst;
  logic [31:0] r_rdata, r_exit_code;
  logic        r_exit_valid;

  logic w_data_req, w_is_exit, w_store, w_full;
  logic w_en, w_wen, w_stall, w_fetch_issue, w_load_issue, w_load_exit, w_exit_set;
  logic [31:0] w_wdata;

  assign w_store    = |wmask;
  assign w_full     = (wmask == 4'hf);
  assign w_data_req = rreq | w_store;
  assign w_is_exit  = (addr == EXIT_ADDR);
  assign sram_addr  = w_data_req ? addr[ADDR_BITS-1:2] : inst_addr[PC_BITS-1:2];

  // Port control; reset gates every strobe so an aborted merge never writes.
  always_comb begin
    w_en          = 1'b0;
    w_wen         = 1'b0;
    w_wdata       = wdata;
    w_stall       = 1'b0;
    w_fetch_issue = 1'b0;
    w_load_issue  = 1'b0;
    w_load_exit   = 1'b0;
    w_exit_set    = 1'b0;
    if (!reset_n) begin
      w_en = 1'b0;
    end else if (r_state == ST_MERGE) begin
      w_en    = 1'b1;
      w_wen   = 1'b1;
      w_wdata = merge(sram_rdata, wdata, wmask);
    end else if (w_store) begin
      if (w_is_exit) begin
        w_exit_set = w_full;
      end else if (w_full) begin
        w_en  = 1'b1;
        w_wen = 1'b1;
      end else begin
        w_en    = 1'b1;
        w_stall = 1'b1;
      end
    end else if (rreq) begin
      if (w_is_exit) begin
        w_load_exit = 1'b1;
      end else begin
        w_en         = 1'b1;
        w_load_issue = 1'b1;
      end
    end else begin
      w_en          = 1'b1;
      w_fetch_issue = 1'b1;
    end
  end

  // FSM plus all registered results.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_load_pend  <= 1'b0;
      r_load_exit  <= 1'b0;
      r_fetch_pend <= 1'b0;
      r_inst_hi    <= 1'b0;
      r_inst_lat   <= 16'h0000;
      r_inst       <= 16'h0000;
      r_rdata      <= 32'h0000_0000;
      r_exit_valid <= 1'b0;
      r_exit_code  <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= w_stall ? ST_MERGE : ST_IDLE;
        ST_MERGE: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
      r_load_pend  <= w_load_issue;
      r_load_exit  <= w_load_exit;
      r_fetch_pend <= w_fetch_issue;
      r_inst_hi    <= inst_addr[1];
      if (r_load_pend) begin
        r_rdata <= sram_rdata;
      end else if (r_load_exit) begin
        r_rdata <= 32'h0000_0000;
      end
      if (r_fetch_pend) begin
        r_inst_lat <= r_inst_hi ? sram_rdata[31:16] : sram_rdata[15:0];
      end
      if (inst_regce) begin
        r_inst <= r_inst_lat;
      end
      if (w_exit_set && !r_exit_valid) begin
        r_exit_valid <= 1'b1;
        r_exit_code  <= wdata;
      end
    end
  end

  assign sram_en    = w_en;
  assign sram_wen   = w_wen;
  assign sram_wdata = w_wdata;
  assign stall      = w_stall;
  assign inst       = r_inst;
  assign rdata      = r_rdata;
  assign exit_valid = r_exit_valid;
  assign exit_code  = r_exit_code;

endmodule

// File: tb/tb_minimax_mem_responder.sv
// Directed bench for minimax_mem_responder backed by the four-bank SRAM mux.
module tb_minimax_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] inst_addr;
  logic        inst_regce;
  logic [15:0] inst;
  logic [31:0] addr, wdata, rdata, sram_wdata, sram_rdata, exit_code;
  logic [3:0]  wmask;
  logic        rreq, stall, sram_en, sram_wen, exit_valid;
  logic [10:0] sram_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minimax_mem_responder dut (
    .clk(clk), .reset_n(reset_n), .inst_addr(inst_addr), .inst_regce(inst_regce),
    .inst(inst), .addr(addr), .wdata(wdata), .wmask(wmask), .rreq(rreq),
    .rdata(rdata), .stall(stall), .sram_en(sram_en), .sram_addr(sram_addr),
    .sram_wen(sram_wen), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .exit_valid(exit_valid), .exit_code(exit_code)
  );

  minimax_sram_bank_mux mem (
    .clk(clk), .sram_en(sram_en), .sram_addr(sram_addr), .sram_wen(sram_wen),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; inst_addr = 13'h0000; inst_regce = 1'b0;
    addr = 32'h0; wdata = 32'h0; wmask = 4'h0; rreq = 1'b0;
    tick(); tick();
    chk("rst_inst", 32'(inst), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_sram_en", 32'(sram_en), 32'h0);
    chk("rst_sram_wen", 32'(sram_wen), 32'h0);
    chk("rst_exit_valid", 32'(exit_valid), 32'h0);
    chk("rst_exit_code", exit_code, 32'h0);

    // Word 0 = 0x1234ABCD via full-word store
    reset_n = 1'b1;
    addr = 32'h0; wdata = 32'h1234_ABCD; wmask = 4'hf;
    #1;
    chk("w0_wen", 32'(sram_wen), 32'h1);
    chk("w0_wdata", sram_wdata, 32'h1234_ABCD);
    chk("w0_stall", 32'(stall), 32'h0);
    tick();
    wmask = 4'h0;

    // Fetch upper halfword
    inst_addr = 13'h0002;
    tick(); tick();
    inst_regce = 1'b1; tick(); inst_regce = 1'b0;
    chk("fetch_hi", 32'(inst), 32'h1234);

    // Fetch lower halfword
    inst_addr = 13'h0000;
    tick(); tick();
    inst_regce = 1'b1; tick(); inst_regce = 1'b0;
    chk("fetch_lo", 32'(inst), 32'hABCD);

    // Full-word store then load at 0x40
    addr = 32'h40; wdata = 32'hDEAD_BEEF; wmask = 4'hf;
    #1;
    chk("fw_stall", 32'(stall), 32'h0);
    chk("fw_addr", 32'(sram_addr), 32'h10);
    tick();
    wmask = 4'h0; rreq = 1'b1;
    #1;
    chk("ld_stall", 32'(stall), 32'h0);
    tick(); rreq = 1'b0;
    tick();
    chk("ld_rdata", rdata, 32'hDEAD_BEEF);

    // Partial store: exactly one stall cycle, merged write
    wdata = 32'h0000_5500; wmask = 4'b0010;
    #1;
    chk("ps_stall_n", 32'(stall), 32'h1);
    chk("ps_rd_wen", 32'(sram_wen), 32'h0);
    tick();
    chk("ps_stall_n1", 32'(stall), 32'h0);
    chk("ps_merge_wen", 32'(sram_wen), 32'h1);
    chk("ps_merge_data", sram_wdata, 32'hDEAD_55EF);
    tick();
    wmask = 4'h0;
    #1;
    chk("ps_stall_n2", 32'(stall), 32'h0);
    rreq = 1'b1; tick(); rreq = 1'b0; tick();
    chk("ps_rdata", rdata, 32'hDEAD_55EF);
    tick();
    chk("rdata_hold", rdata, 32'hDEAD_55EF);

    // Far bank and address alias beyond ADDR_BITS
    addr = 32'h1FFC; wdata = 32'hCAFE_F00D; wmask = 4'hf;
    #1;
    chk("bank3_addr", 32'(sram_addr), 32'h7FF);
    tick();
    wmask = 4'h0; rreq = 1'b1; tick(); rreq = 1'b0; tick();
    chk("bank3_rdata", rdata, 32'hCAFE_F00D);
    addr = 32'h2040; rreq = 1'b1; tick(); rreq = 1'b0; tick();
    chk("alias_rdata", rdata, 32'hDEAD_55EF);

    // Fetch displaced by a data read leaves inst_lat alone
    inst_addr = 13'h0000; tick(); tick();
    inst_addr = 13'h0002; addr = 32'h40; rreq = 1'b1;
    #1;
    chk("arb_addr", 32'(sram_addr), 32'h10);
    chk("arb_wen", 32'(sram_wen), 32'h0);
    tick();
    inst_regce = 1'b1; tick(); tick();
    inst_regce = 1'b0; rreq = 1'b0; inst_addr = 13'h0000;
    chk("arb_inst", 32'(inst), 32'hABCD);
    chk("arb_rdata", rdata, 32'hDEAD_55EF);

    // Exit register
    addr = 32'hFFFF_FFFC; wdata = 32'h5; wmask = 4'b0011;
    #1;
    chk("exit_part_stall", 32'(stall), 32'h0);
    chk("exit_part_en", 32'(sram_en), 32'h0);
    tick();
    chk("exit_part_valid", 32'(exit_valid), 32'h0);
    wdata = 32'h0; wmask = 4'hf;
    #1;
    chk("exit_full_en", 32'(sram_en), 32'h0);
    tick();
    chk("exit_valid", 32'(exit_valid), 32'h1);
    chk("exit_code0", exit_code, 32'h0);
    wdata = 32'h7; tick();
    chk("exit_sticky", exit_code, 32'h0);
    wmask = 4'h0; rreq = 1'b1;
    #1;
    chk("exit_rd_en", 32'(sram_en), 32'h0);
    tick(); rreq = 1'b0; tick();
    chk("exit_rdata", rdata, 32'h0);

    // Reset during MERGE aborts the store
    addr = 32'h40; wdata = 32'h0000_00AA; wmask = 4'b0001;
    tick();
    reset_n = 1'b0;
    #1;
    chk("abort_wen", 32'(sram_wen), 32'h0);
    chk("abort_en", 32'(sram_en), 32'h0);
    tick();
    reset_n = 1'b1; wmask = 4'h0;
    #1;
    chk("abort_stall", 32'(stall), 32'h0);
    chk("abort_idle_wen", 32'(sram_wen), 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_inst", 32'(inst), 32'h0);
    chk("abort_exit_valid", 32'(exit_valid), 32'h0);
    chk("abort_exit_code", exit_code, 32'h0);
    rreq = 1'b1; tick(); rreq = 1'b0; tick();
    chk("abort_mem", rdata, 32'hDEAD_55EF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minimax_mem_responder.md
# minimax_mem_responder

Memory-side responder for the minimax core bus. It accepts instruction fetches (`inst_addr`) and data accesses (`addr`/`wdata`/`wmask`/`rreq`) and arbitrates them onto one single-port, word-write-only synchronous SRAM array. Partial-word stores are handled by a read-modify-write sequencer. A write-only exit register at `EXIT_ADDR` ends simulation or firmware runs. The block sits between the core and the 512x32 SRAM banks, replacing the ad hoc glue previously built around the core.

## Interface
- `PC_BITS`, 13, width of `inst_addr`.
- `ADDR_BITS`, 13, byte-address bits decoded for the SRAM (8 KiB); upper bits alias.
- `EXIT_ADDR`, 32'hfffffffc, address of the exit register.
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `inst_addr` in PC_BITS: halfword-aligned fetch address.
- `inst_regce` in 1: load `inst` from the fetch latch.
- `inst` out 16: instruction halfword to the core.
- `addr` in 32: data byte address.
- `wdata` in 32: store data, lane-aligned.
- `wmask` in 4: byte-lane write enables; 0 means no store.
- `rreq` in 1: data read request.
- `rdata` out 32: registered load data.
- `stall` out 1: the core must hold its `addr`, `wdata` and `wmask` while this is high.
- `sram_en` out 1: SRAM access enable.
- `sram_addr` out ADDR_BITS-2: SRAM word address.
- `sram_wen` out 1: full-word write.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, valid one cycle after address.
- `exit_valid` out 1: sticky flag, set on the first full-word write to `EXIT_ADDR`.
- `exit_code` out 32: value captured by that write.

## Operation
- A data request is `rreq | (|wmask)`. A data request wins over a fetch in the same cycle. A fetch uses the SRAM only when there is no data request.
- `sram_addr` is selected combinationally: `addr[ADDR_BITS-1:2]` for data, `inst_addr[PC_BITS-1:2]` for a fetch.
- FSM states are IDLE and MERGE.
- IDLE, transitions:
  - `wmask==4'hf` → single-cycle write with `sram_wen=1` and `sram_wdata=wdata`; stay in IDLE.
  - `wmask` nonzero but not 4'hf → issue a read (`sram_en=1`, `sram_wen=0`), set `stall=1`, go to MERGE.
  - `rreq` → issue a read; stay in IDLE.
- MERGE: per byte lane, write `wmask[i] ? wdata : sram_rdata`; drive `sram_wen=1`; set `stall=0`; return to IDLE. A partial store therefore stalls for exactly 1 cycle.
- Any write with `addr==EXIT_ADDR` never reaches the SRAM.
  - `wmask==4'hf`: if `exit_valid` is 0, set `exit_valid=1` and `exit_code=wdata`. Later exit writes are ignored.
  - Partial writes to `EXIT_ADDR` are dropped and never stall.
- Reads of `EXIT_ADDR` return 0.
- Fetch latch: `inst_lat` takes `sram_rdata[15:0]` when the registered `inst_addr[1]` is 0, else `sram_rdata[31:16]`.
  - `inst_lat` updates only in a cycle following a fetch that was actually issued.
  - `inst` loads `inst_lat` when `inst_regce` is high.

## Timing
- Load: `rreq` in cycle N → `sram_rdata` in N+1 → `rdata` registered at the end of N+1, valid in N+2.
- `rdata` holds its value until the next load completes.
- Fetch: same two-cycle path into `inst_lat`. A fetch displaced by a data request is not retried by this block; the core re-presents it.
- Full-word store: committed at the edge ending cycle N.
- Partial store: read in N, merged write at the edge ending N+1; `stall` is high during N only.
- Reset values: `inst=0`, `rdata=0`, `stall=0`, `sram_en=0`, `sram_wen=0`, `exit_valid=0`, `exit_code=0`, FSM in IDLE.
- Reset asserted during MERGE aborts the store: no SRAM write occurs and the FSM is in IDLE on the next cycle.
- `rreq` together with a nonzero `wmask` is treated as a store; no `rdata` update.
- Address wrap: bits at and above `ADDR_BITS` are ignored, except for the exact `EXIT_ADDR` compare.

## Structure
- Shared package `minimax_mem_pkg` holds:
  - the FSM state enum (IDLE, MERGE);
  - the `EXIT_ADDR` default;
  - a byte-merge function `merge(old, new, mask)`.
- One sub-module, `minimax_sram_bank_mux`, maps the `sram_*` port onto four 512x32 banks. Bank select is `sram_addr[ADDR_BITS-3:ADDR_BITS-4]`; read data is AND-OR muxed using the registered bank select.

## Test plan
- Fetch `inst_addr=0x002` with SRAM word 0 = 0x1234ABCD, pulse `inst_regce` 2 cycles later → `inst=0x1234`. With `inst_addr=0x000` → `0xABCD`.
- Store `addr=0x40`, `wmask=4'hf`, `wdata=0xDEADBEEF`, then `rreq` at 0x40 → `rdata=0xDEADBEEF` two cycles after the request; `stall` never asserts.
- Word 0x40 = 0xDEADBEEF, then store `wmask=4'b0010`, `wdata=0x00005500` → `stall` high exactly 1 cycle; a subsequent read returns 0xDEAD55EF.
- Fetch and `rreq` in the same cycle → SRAM address comes from `addr`; `inst_lat` is unchanged.
- Full-word write of 0 to 0xFFFFFFFC, then a write of 7 → `exit_valid=1`, `exit_code=0`, no SRAM write. A partial write there first → no effect.
- Deassert `reset_n` during MERGE → no SRAM write; all outputs at their reset values on the next cycle.
